// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between a producer of binary values and the
// sequential binary-to-BCD converter feeding the 8-digit display.
interface bin_to_bcd_seq_if #(
  parameter int W_BIN    = 27,
  parameter int W_DIGITS = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [W_BIN-1:0]      in_bin;
  logic                  out_valid;
  logic [4*W_DIGITS-1:0] bcd;
  logic [W_DIGITS-1:0]   digit_mask;
  logic                  overflow;
  logic                  busy;

  // Producer side: issues requests, observes results.
  modport master (
    output in_valid, in_bin,
    input  in_ready, out_valid, bcd, digit_mask, overflow, busy
  );

  // Converter side.
  modport slave (
    input  in_valid, in_bin,
    output in_ready, out_valid, bcd, digit_mask, overflow, busy
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter, one input bit per clock. A request is
// accepted in IDLE or DONE, shifted for W_BIN cycles, and the packed BCD
// result (D0 in the low nibble), significance mask and saturation flag are
// registered on the edge that enters DONE.
module bin_to_bcd_seq #(
  parameter int W_BIN    = 27,
  parameter int W_DIGITS = 8
) (
  input  logic            clock,
  input  logic            reset,
  bin_to_bcd_seq_if.slave bus
);
  localparam int BCD_W = 4 * W_DIGITS;
  localparam int TOT_W = BCD_W + W_BIN;
  localparam int CNT_W = (W_BIN > 1) ? $clog2(W_BIN) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W_BIN - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  // Largest value representable in W_DIGITS decimal digits.
  localparam logic [63:0] MAX_DEC = pow10(W_DIGITS) - 64'd1;
  localparam logic [BCD_W-1:0] ALL_NINES = {W_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [TOT_W-1:0]   shift_reg;
  logic [TOT_W-1:0]   adj;
  logic [TOT_W-1:0]   shift_next;
  logic [CNT_W-1:0]   iter_cnt_reg;
  logic               ovf_pend_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic [W_DIGITS-1:0] mask_reg;
  logic               ovf_reg;
  logic [BCD_W-1:0]   final_bcd;
  logic [W_DIGITS-1:0] final_mask;
  logic               ready;
  logic               busy;
  logic               done;
  logic               accept;
  logic               last_iter;
  logic               ovf_now;

  assign accept    = bus.in_valid && ready;
  assign last_iter = (iter_cnt_reg == LAST_ITER);
  assign ovf_now   = (64'(bus.in_bin) > MAX_DEC);

  // Add-3 correction per BCD nibble; nibbles never carry into each other,
  // and the binary part below the BCD field passes through untouched.
  assign adj[W_BIN-1:0] = shift_reg[W_BIN-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < W_DIGITS; gi++) begin : g_add3
      logic [3:0] nib;
      assign nib = shift_reg[W_BIN + 4*gi +: 4];
      assign adj[W_BIN + 4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  // The bit leaving the BCD MSB is dropped; saturation covers that case.
  assign shift_next = adj << 1;
  assign final_bcd  = shift_next[TOT_W-1 -: BCD_W];

  // Digit i is significant when it or any more significant digit is nonzero.
  assign final_mask[0] = 1'b1;
  generate
    for (gi = 1; gi < W_DIGITS; gi++) begin : g_mask
      assign final_mask[gi] = |final_bcd[BCD_W-1:4*gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next state and state-decoded handshake/status outputs.
  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (bus.in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        done       = 1'b1;
        state_next = bus.in_valid ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register, iteration counter and pending-saturation flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift_reg    <= '0;
      iter_cnt_reg <= '0;
      ovf_pend_reg <= 1'b0;
    end else if (accept) begin
      shift_reg    <= {{BCD_W{1'b0}}, bus.in_bin};
      iter_cnt_reg <= '0;
      ovf_pend_reg <= ovf_now;
    end else if (state_reg == SHIFT) begin
      shift_reg    <= shift_next;
      iter_cnt_reg <= iter_cnt_reg + CNT_W'(1);
    end
  end

  // Result registers, loaded only on the edge that enters DONE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_reg  <= '0;
      mask_reg <= W_DIGITS'(1);
      ovf_reg  <= 1'b0;
    end else if (state_reg == SHIFT && last_iter) begin
      if (ovf_pend_reg) begin
        bcd_reg  <= ALL_NINES;
        mask_reg <= '1;
        ovf_reg  <= 1'b1;
      end else begin
        bcd_reg  <= final_bcd;
        mask_reg <= final_mask;
        ovf_reg  <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.busy       = busy;
  assign bus.out_valid  = done;
  assign bus.bcd        = bcd_reg;
  assign bus.digit_mask = mask_reg;
  assign bus.overflow   = ovf_reg;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed vectors with literal expectations plus
// a decimal-arithmetic reference model checked on every cycle.
`timescale 1ns/1ps
module tb_bin_to_bcd_seq;
  localparam int W_BIN    = 27;
  localparam int W_DIGITS = 8;
  // Edges from the accept edge to the edge after which out_valid shows
  // (28 edges counting the accept edge itself).
  localparam longint LAT = W_BIN;
  localparam longint MAX_DEC = 64'd99_999_999;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  longint edge_cnt = 0;

  bin_to_bcd_seq_if #(.W_BIN(W_BIN), .W_DIGITS(W_DIGITS)) bus();

  bin_to_bcd_seq #(.W_BIN(W_BIN), .W_DIGITS(W_DIGITS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter used to time results against their accept edge.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain decimal digit extraction with saturation.
  function automatic logic [31:0] model_bcd(input longint v);
    logic [31:0] r;
    longint x;
    r = '0;
    x = v;
    if (v > MAX_DEC) return 32'h99999999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] model_mask(input longint v);
    logic [7:0] m;
    longint p;
    m = 8'h01;
    p = 10;
    if (v > MAX_DEC) return 8'hFF;
    for (int i = 1; i < 8; i++) begin
      if (v >= p) m[i] = 1'b1;
      p = p * 10;
    end
    return m;
  endfunction

  typedef struct {
    longint v;
    longint edge_no;
  } job_t;

  job_t        q[$];
  logic        pend = 1'b0;
  logic [26:0] pend_v = '0;
  logic [31:0] last_bcd = '0;
  logic [7:0]  last_mask = 8'h01;
  logic        last_ovf = 1'b0;

  // Scoreboard: records accepts, predicts when each result must appear,
  // and checks every output on every falling edge.
  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      pend      = 1'b0;
      last_bcd  = '0;
      last_mask = 8'h01;
      last_ovf  = 1'b0;
    end else begin
      logic exp_valid;
      job_t j;
      if (pend) begin
        j.v       = longint'(pend_v);
        j.edge_no = edge_cnt;
        q.push_back(j);
      end
      exp_valid = (q.size() != 0) && (edge_cnt - q[0].edge_no == LAT);
      check("out_valid", bus.out_valid, exp_valid);
      if (exp_valid) begin
        j = q.pop_front();
        check("bcd", bus.bcd, model_bcd(j.v));
        check("digit_mask", bus.digit_mask, model_mask(j.v));
        check("overflow", bus.overflow, j.v > MAX_DEC);
        last_bcd  = bus.bcd;
        last_mask = bus.digit_mask;
        last_ovf  = bus.overflow;
      end else begin
        check("hold", {bus.bcd, bus.digit_mask, bus.overflow},
              {last_bcd, last_mask, last_ovf});
      end
      check("busy", bus.busy, q.size() != 0);
      check("in_ready", bus.in_ready, q.size() == 0);
      pend   = bus.in_valid && bus.in_ready;
      pend_v = bus.in_bin;
    end
  end

  task automatic send(input logic [26:0] v);
    int t;
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_bin   = v;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    check("ready_wait", t < 100, 1'b1);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
  endtask

  // Returns on the falling edge where out_valid is high.
  task automatic wait_result;
    int t;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!bus.out_valid && t < 100);
    check("result_wait", bus.out_valid, 1'b1);
  endtask

  task automatic run_lit(input logic [26:0] v, input logic [31:0] e_bcd,
                         input logic [7:0] e_mask, input logic e_ovf);
    send(v);
    wait_result();
    check("lit_bcd", bus.bcd, e_bcd);
    check("lit_mask", bus.digit_mask, e_mask);
    check("lit_ovf", bus.overflow, e_ovf);
    $display("conv in=%0d bcd=%08h mask=%02h ovf=%0b", v, bus.bcd, bus.digit_mask, bus.overflow);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_bcd"}, bus.bcd, 32'h0);
    check({tag, "_mask"}, bus.digit_mask, 8'h01);
    check({tag, "_ovf"}, bus.overflow, 1'b0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_busy"}, bus.busy, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [26:0] rv;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_bin   = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_vals("reset");

    check("model_pin_bcd", model_bcd(12_345_678), 32'h12345678);
    check("model_pin_mask", model_mask(1_000), 8'h0F);
    check("model_pin_sat", model_bcd(100_000_000), 32'h99999999);
    check("model_pin_zero", model_mask(0), 8'h01);

    run_lit(27'd0,           32'h00000000, 8'h01, 1'b0);
    run_lit(27'd12_345_678,  32'h12345678, 8'hFF, 1'b0);
    run_lit(27'd1_000,       32'h00001000, 8'h0F, 1'b0);
    run_lit(27'd99_999_999,  32'h99999999, 8'hFF, 1'b0);
    run_lit(27'd100_000_000, 32'h99999999, 8'hFF, 1'b1);
    run_lit(27'd134_217_727, 32'h99999999, 8'hFF, 1'b1);

    // Held in_valid: operand changes mid-conversion must not be taken.
    @(posedge clock); #1;
    bus.in_valid = 1'b1;
    bus.in_bin   = 27'd42;
    @(posedge clock); #1;
    bus.in_bin = 27'd7;
    check("ready_in_shift", bus.in_ready, 1'b0);
    wait_result();
    check("b2b_first", bus.bcd, 32'h00000042);
    $display("b2b first bcd=%08h", bus.bcd);
    @(posedge clock); #1;
    bus.in_valid = 1'b0;
    wait_result();
    check("b2b_second", bus.bcd, 32'h00000007);
    $display("b2b second bcd=%08h", bus.bcd);

    // Reset in the middle of a conversion.
    send(27'd12_345_678);
    repeat (9) @(posedge clock);
    #1 reset = 1'b1;
    #1 check_reset_vals("midreset");
    $display("mid-conversion reset applied");
    @(posedge clock); #1;
    reset = 1'b0;
    run_lit(27'd5, 32'h00000005, 8'h01, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      rv = 27'($urandom_range(0, 134_217_727));
      send(rv);
      wait_result();
      $display("rand %0d in=%0d bcd=%08h mask=%02h ovf=%0b", i, rv, bus.bcd, bus.digit_mask, bus.overflow);
    end

    repeat (5) @(negedge clock);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
